// File: rtl/nco_cfg_writer.sv
// nco_cfg_writer
// Deserialises configuration frames from a bit-serial stream. The frame
// layout is a start-of-frame bit followed by the address bits and then the
// data bits, MSB first. A completed frame is written to a bank of register
// cells. The write uses a one-hot strobe and a shared data bus.
//
// Optional feature: when the macro NCO_CFG_PARITY_EN is defined, each frame
// carries one trailing even-parity bit. That bit covers the address and data
// bits. A frame with the wrong parity is rejected.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ser_valid_i  serial bit valid
//   ser_data_i   serial bit value (MSB first)
//   ser_sof_i    first bit of a frame (qualified by ser_valid_i)
//   ser_ready_o  a bit is accepted this cycle when ser_valid_i is also 1
//   din_o        last fully assembled data word, bit i feeds cell i
//   set_o        one-hot write strobe, one bit per register
//   done_o       one-cycle pulse: frame written
//   err_o        one-cycle pulse: frame rejected (bad address or parity)
module nco_cfg_writer #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ser_valid_i,
    input  logic                ser_data_i,
    input  logic                ser_sof_i,
    output logic                ser_ready_o,
    output logic [DATA_W-1:0]   din_o,
    output logic [NUM_REGS-1:0] set_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
`ifdef NCO_CFG_PARITY_EN
        PAR,
`endif
        WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic [NUM_REGS-1:0]   set_q, set_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  finish;
`ifdef NCO_CFG_PARITY_EN
    logic                  par_q, par_d;
    logic                  par_bad;
`endif

    // An out-of-range address decodes to an all-zero strobe. That makes
    // "address valid" simply the OR of the decode.
    function automatic logic [NUM_REGS-1:0] addr_strobe(input logic [ADDR_W-1:0] a);
        addr_strobe = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            addr_strobe[r] = (int'(a) == r);
        end
    endfunction

    assign ser_ready_o = (state_q != WRITE);
    assign accept      = ser_valid_i && ser_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        din_d   = din_q;
        set_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        finish  = 1'b0;
`ifdef NCO_CFG_PARITY_EN
        par_d   = par_q;
        par_bad = 1'b0;
`endif

        if (accept && ser_sof_i) begin
            // A start bit is accepted in any state. Any partial frame in
            // progress is dropped silently, and the start bit becomes the
            // address MSB.
            addr_d  = ADDR_W'(ser_data_i);
            cnt_d   = (ADDR_W == 1) ? '0 : CNT_W'(1);
            state_d = (ADDR_W == 1) ? DATA : ADDR;
`ifdef NCO_CFG_PARITY_EN
            par_d   = ser_data_i;
`endif
        end else if (accept) begin
            case (state_q)
                ADDR: begin
                    addr_d = (addr_q << 1) | ADDR_W'(ser_data_i);
`ifdef NCO_CFG_PARITY_EN
                    par_d  = par_q ^ ser_data_i;
`endif
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    shift_d = (shift_q << 1) | DATA_W'(ser_data_i);
`ifdef NCO_CFG_PARITY_EN
                    par_d   = par_q ^ ser_data_i;
`endif
                    if (cnt_q == DATA_LAST) begin
                        // Publish the word once it is complete. The cells
                        // then never see a half-shifted value.
                        din_d = shift_d;
                        cnt_d = '0;
`ifdef NCO_CFG_PARITY_EN
                        state_d = PAR;
`else
                        state_d = WRITE;
                        finish  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef NCO_CFG_PARITY_EN
                PAR: begin
                    par_bad = par_q ^ ser_data_i;
                    state_d = WRITE;
                    finish  = 1'b1;
                end
`endif
                default: ;  // IDLE: bits without a start flag are dropped
            endcase
        end else if (state_q == WRITE) begin
            state_d = IDLE;
        end

        // Strobes are computed on entry to WRITE and registered. As a
        // result they are high exactly during the single WRITE cycle.
        if (finish) begin
`ifdef NCO_CFG_PARITY_EN
            if (!par_bad && (|addr_strobe(addr_q))) begin
`else
            if (|addr_strobe(addr_q)) begin
`endif
                set_d  = addr_strobe(addr_q);
                done_d = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            din_q   <= '0;
            set_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef NCO_CFG_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            din_q   <= din_d;
            set_q   <= set_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef NCO_CFG_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign din_o  = din_q;
    assign set_o  = set_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_nco_cfg_writer.sv
module tb_nco_cfg_writer;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 4;
`ifdef NCO_CFG_PARITY_EN
    localparam int PAR_EN   = 1;
`else
    localparam int PAR_EN   = 0;
`endif
    localparam int FRAME_LEN = ADDR_W + DATA_W + PAR_EN;

    logic                clk;
    logic                rst_n;
    logic                ser_valid_i;
    logic                ser_data_i;
    logic                ser_sof_i;
    logic                ser_ready_o;
    logic [DATA_W-1:0]   din_o;
    logic [NUM_REGS-1:0] set_o;
    logic                done_o;
    logic                err_o;

    nco_cfg_writer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ser_valid_i (ser_valid_i),
        .ser_data_i  (ser_data_i),
        .ser_sof_i   (ser_sof_i),
        .ser_ready_o (ser_ready_o),
        .din_o       (din_o),
        .set_o       (set_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted frame bits collected in a queue, plus the
    // outputs expected during the current cycle.
    bit                  mq[$];
    bit                  m_in_frame;
    logic [NUM_REGS-1:0] e_set;
    logic                e_done, e_err, e_ready;
    logic [DATA_W-1:0]   e_din;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_in_frame = 1'b0;
        e_set   = '0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_ready = 1'b1;
        e_din   = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance
    // the model, then move to the next falling edge.
    task automatic step(input bit v, input bit d, input bit s);
        bit          acc;
        int unsigned a;
        logic [DATA_W-1:0] w;
        int          ones;
        bit          ok;
        ser_valid_i = v;
        ser_data_i  = d;
        ser_sof_i   = s;
        check_eq("ready", 64'(ser_ready_o), 64'(e_ready));
        check_eq("set",   64'(set_o),       64'(e_set));
        check_eq("done",  64'(done_o),      64'(e_done));
        check_eq("err",   64'(err_o),       64'(e_err));
        check_eq("din",   64'(din_o),       64'(e_din));

        acc     = v && e_ready;
        e_set   = '0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_ready = 1'b1;
        if (acc) begin
            if (s) begin
                mq.delete();
                mq.push_back(d);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                mq.push_back(d);
            end
            if (m_in_frame && mq.size() == ADDR_W + DATA_W) begin
                w = '0;
                for (int i = ADDR_W; i < ADDR_W + DATA_W; i++) w = (w << 1) | DATA_W'(mq[i]);
                e_din = w;
            end
            if (m_in_frame && mq.size() == FRAME_LEN) begin
                a = 0;
                for (int i = 0; i < ADDR_W; i++) a = (a << 1) | 32'(mq[i]);
                ones = 0;
                foreach (mq[i]) ones += int'(mq[i]);
                ok = (PAR_EN == 0) || (ones % 2 == 0);
                if (ok && a < NUM_REGS) begin
                    e_set  = NUM_REGS'(1) << a;
                    e_done = 1'b1;
                end else begin
                    e_err  = 1'b1;
                end
                e_ready    = 1'b0;
                m_in_frame = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit frame_bit(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                     input bit flip, input int i);
        if (i < ADDR_W) return a[ADDR_W-1-i];
        if (i < ADDR_W + DATA_W) return d[DATA_W-1-(i-ADDR_W)];
        return (^a) ^ (^d) ^ flip;
    endfunction

    task automatic send_bits(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input int first, input int last, input int gap, input bit flip);
        for (int i = first; i <= last; i++) begin
            step(1'b1, frame_bit(a, d, flip, i), i == 0);
            if (i != last) repeat (gap) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_eq("rst_set",   64'(set_o),       64'h0);
        check_eq("rst_din",   64'(din_o),       64'h0);
        check_eq("rst_done",  64'(done_o),      64'h0);
        check_eq("rst_err",   64'(err_o),       64'h0);
        check_eq("rst_ready", 64'(ser_ready_o), 64'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [ADDR_W-1:0] ra, ra2;
        logic [DATA_W-1:0] rd, rd2;
        rst_n       = 1'b1;
        ser_valid_i = 1'b0;
        ser_data_i  = 1'b0;
        ser_sof_i   = 1'b0;
        @(negedge clk);
        do_reset();
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Back-to-back frame to register 2
        send_bits(4'd2, 32'hDEADBEEF, 0, FRAME_LEN - 1, 0, 1'b0);
        check_eq("r030_set",   64'(set_o),       64'h4);
        check_eq("r030_din",   64'(din_o),       64'hDEADBEEF);
        check_eq("r030_done",  64'(done_o),      64'h1);
        check_eq("r030_ready", 64'(ser_ready_o), 64'h0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("r030_done_off", 64'(done_o), 64'h0);

        // Out-of-range address
        send_bits(4'd5, 32'h0BADF00D, 0, FRAME_LEN - 1, 0, 1'b0);
        check_eq("r031_err", 64'(err_o), 64'h1);
        check_eq("r031_set", 64'(set_o), 64'h0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("r031_idle", 64'(ser_ready_o), 64'h1);
        check_eq("r031_err_off", 64'(err_o), 64'h0);

        // Three idle cycles after every bit
        send_bits(4'd1, 32'h00000001, 0, FRAME_LEN - 1, 3, 1'b0);
        check_eq("r032_set", 64'(set_o), 64'h2);
        check_eq("r032_din", 64'(din_o), 64'h1);
        step(1'b0, 1'b0, 1'b0);

        // Restart at bit 20 with a full frame
        send_bits(4'd3, 32'hCAFEF00D, 0, 19, 0, 1'b0);
        send_bits(4'd0, 32'h12345678, 0, FRAME_LEN - 1, 0, 1'b0);
        check_eq("r033_set", 64'(set_o), 64'h1);
        check_eq("r033_din", 64'(din_o), 64'h12345678);
        check_eq("r033_err", 64'(err_o), 64'h0);
        step(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a frame
        send_bits(4'd1, 32'hA5A5A5A5, 0, 9, 0, 1'b0);
        do_reset();
        send_bits(4'd1, 32'hA5A5A5A5, 10, FRAME_LEN - 1, 0, 1'b0);
        check_eq("r034_set",  64'(set_o),  64'h0);
        check_eq("r034_done", 64'(done_o), 64'h0);
        check_eq("r034_err",  64'(err_o),  64'h0);
        repeat (3) step(1'b0, 1'b0, 1'b0);

`ifdef NCO_CFG_PARITY_EN
        send_bits(4'd3, 32'h1, 0, FRAME_LEN - 1, 0, 1'b0);
        check_eq("r035_set_good", 64'(set_o), 64'h8);
        step(1'b0, 1'b0, 1'b0);
        send_bits(4'd3, 32'h1, 0, FRAME_LEN - 1, 0, 1'b1);
        check_eq("r035_err_bad", 64'(err_o), 64'h1);
        check_eq("r035_set_bad", 64'(set_o), 64'h0);
        step(1'b0, 1'b0, 1'b0);
`endif

        // Randomized frames: mixed addresses, gaps, aborts, parity flips, noise
        for (int n = 0; n < 150; n++) begin
            ra  = ADDR_W'($urandom_range(0, 7));
            rd  = $urandom;
            if ($urandom_range(0, 5) == 0) begin
                ra2 = ADDR_W'($urandom);
                rd2 = $urandom;
                send_bits(ra2, rd2, 0, $urandom_range(0, FRAME_LEN - 2), 0, 1'b0);
            end
            send_bits(ra, rd, 0, FRAME_LEN - 1, $urandom_range(0, 2), $urandom_range(0, 4) == 0);
            step(1'b0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) step(1'($urandom), 1'($urandom), 1'b0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_cfg_writer.md
NCO_CFG_WRITER -- requirements
Module: nco_cfg_writer

Interface
REQ-001 Parameter ADDR_W, default 4: address field width in bits.
REQ-002 Parameter DATA_W, default 32: data field width; one set strobe drives DATA_W single-bit register cells.
REQ-003 Parameter NUM_REGS, default 4: number of addressable registers, with NUM_REGS <= 2^ADDR_W.
REQ-004 clk  input  1: single clock; all logic on rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 ser_valid_i  input  1: serial bit valid.
REQ-007 ser_data_i  input  1: serial bit value, MSB first.
REQ-008 ser_sof_i  input  1: marks the first bit of a frame; qualified by ser_valid_i.
REQ-009 ser_ready_o  output  1: writer accepts a bit this cycle.
REQ-010 din_o  output  DATA_W: data to register cells, bit i feeds cell i.
REQ-011 set_o  output  NUM_REGS: one-hot write strobe per register.
REQ-012 done_o  output  1: one-cycle pulse, frame written.
REQ-013 err_o  output  1: one-cycle pulse, frame rejected.

Function
REQ-014 A bit is accepted only when ser_valid_i and ser_ready_o are both 1.
REQ-015 The FSM SHALL have states IDLE, ADDR, DATA, PAR, WRITE; PAR is present only when the configuration feature is compiled in.
REQ-016 ser_ready_o is 1 in IDLE, ADDR, DATA and PAR, and 0 in WRITE.
REQ-017 IDLE: a bit accepted with ser_sof_i=1 is address MSB, go ADDR (or DATA if ADDR_W=1); accepted bits with ser_sof_i=0 are discarded.
REQ-018 ADDR: shift ADDR_W bits total, then DATA; DATA: shift DATA_W bits, then PAR (feature in) or WRITE (feature out).
REQ-019 An accepted bit with ser_sof_i=1 in ADDR/DATA/PAR aborts the frame, no err_o, and restarts it with that bit as address MSB.
REQ-020 WRITE lasts exactly one cycle, then IDLE; set_o, done_o, err_o are registered and pulse only during WRITE.
REQ-021 In WRITE, if address < NUM_REGS and no parity error: set_o[address]=1, done_o=1; else set_o all 0, err_o=1.
REQ-022 din_o holds the last assembled data word, is stable whenever any set_o bit is 1, and changes only on accepted DATA bits.
REQ-023 Latency: set_o asserts on the cycle after the last frame bit is accepted.
REQ-024 Gaps with ser_valid_i=0 mid-frame are allowed indefinitely; the bit counter holds.
REQ-025 At most one set_o bit is 1 in any cycle.

Reset
REQ-026 rst_n low: state IDLE, counters 0, din_o 0, set_o 0, done_o 0, err_o 0; ser_ready_o is then 1 (IDLE).
REQ-027 Reset mid-frame discards the partial frame; no strobe is issued after release.

Configuration
REQ-028 Macro NCO_CFG_PARITY_EN defined: each frame carries one trailing even-parity bit over the address and data bits (total of all ADDR_W+DATA_W+1 bits even); a mismatch gives err_o with no set_o.
REQ-029 Macro NCO_CFG_PARITY_EN undefined: no PAR state; the frame is ADDR_W+DATA_W bits and is never rejected for parity.

Verification (defaults; feature off unless noted)
REQ-030 Frame addr=2, data=0xDEADBEEF sent back-to-back -> one cycle after the 36th bit: set_o=4'b0100, din_o=0xDEADBEEF, done_o=1 for exactly one cycle, ser_ready_o=0 in that cycle.
REQ-031 Frame addr=5 -> err_o=1 for one cycle, set_o=0, FSM back in IDLE.
REQ-032 Frame addr=1, data=0x00000001 with ser_valid_i low for 3 cycles after every bit -> set_o=4'b0010 with din_o=0x00000001; no strobe before the 36th bit.
REQ-033 ser_sof_i reasserted at bit 20 followed by a full addr=0, data=0x12345678 frame -> a single set_o=4'b0001 pulse with din_o=0x12345678, no err_o.
REQ-034 rst_n pulsed low at bit 10 of a frame, then the rest of the bits sent without ser_sof_i -> no set_o, done_o or err_o.
REQ-035 NCO_CFG_PARITY_EN defined, addr=3, data=0x1 -> parity bit 1 gives set_o=4'b1000; parity bit 0 gives err_o and no set_o.
